// File: rtl/a2d_rr_intf.sv
// Round-robin SPI front end for the ADC128S A2D: cycles left load cell, right load cell,
// steering pot and battery, two SPI transactions per reading, with a built-in SPI master.
module a2d_rr_intf #(
  parameter int         SCLK_DIV_W = 5,
  parameter logic [2:0] CH_LFT     = 3'd0,
  parameter logic [2:0] CH_RGHT    = 3'd4,
  parameter logic [2:0] CH_STEER   = 3'd5,
  parameter logic [2:0] CH_BATT    = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, UPD} state_t;

  localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = {1'b1, 1'b0, {(SCLK_DIV_W-2){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;

  state_t                state, state_nxt;
  logic [1:0]            ptr;
  logic [2:0]            ch_sel;
  logic [15:0]           cmd, shft_reg, rx_word;
  logic [SCLK_DIV_W-1:0] div, div_inc;
  logic [3:0]            shft_cnt;
  logic                  start, done, porch, shadow;

  always_comb begin
    case (ptr)
      2'd0:    ch_sel = CH_LFT;
      2'd1:    ch_sel = CH_RGHT;
      2'd2:    ch_sel = CH_STEER;
      default: ch_sel = CH_BATT;
    endcase
  end

  assign cmd     = {2'b00, ch_sel, 11'h000};
  assign rx_word = {shft_reg[14:0], shadow};
  assign div_inc = div + SCLK_DIV_W'(1);
  assign MOSI    = shft_reg[15];
  // The 16th counted shift ends the transaction; the front-porch fall is never counted.
  assign done    = !SS_n && (div == DIV_FALL) && !porch && (shft_cnt == 4'd15);

  // SPI engine: SCLK is registered so it cannot glitch when SS_n and the divider change together.
  // NOTE: every sequential register uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n     <= 1'b1;
      SCLK     <= 1'b1;
      div      <= '0;
      shft_reg <= '0;
      shft_cnt <= '0;
      porch    <= 1'b0;
      shadow   <= 1'b0;
    end else if (start) begin
      SS_n     <= 1'b0;
      SCLK     <= 1'b1;
      div      <= DIV_LOAD;
      shft_reg <= cmd;
      shft_cnt <= '0;
      porch    <= 1'b1;
    end else if (!SS_n) begin
      div  <= div_inc;
      SCLK <= done ? 1'b1 : div_inc[SCLK_DIV_W-1];
      if (div == DIV_RISE) shadow <= MISO;
      if (div == DIV_FALL) begin
        if (porch) begin
          porch <= 1'b0;
        end else begin
          shft_reg <= rx_word;
          shft_cnt <= shft_cnt + 4'd1;
        end
      end
      if (done) SS_n <= 1'b1;
    end
  end

  // NOTE: defaults first so no path through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (nxt) begin
        start     = 1'b1;
        state_nxt = CMD;
      end
      CMD:  if (done) state_nxt = GAP;
      GAP: begin
        start     = 1'b1;
        state_nxt = READ;
      end
      READ: if (done) state_nxt = UPD;
      UPD:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == CMD) || (state == GAP) || (state == READ);
  assign cnv_cmplt = (state == UPD);

  // Result lands on the edge entering UPD so the new value is visible alongside cnv_cmplt.
  // NOTE: output registers are reset so the balance logic never sees X before the first conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      state <= state_nxt;
      if (state == READ && done) begin
        case (ptr)
          2'd0:    lft_ld    <= rx_word[11:0];
          2'd1:    rght_ld   <= rx_word[11:0];
          2'd2:    steer_pot <= rx_word[11:0];
          default: batt      <= rx_word[11:0];
        endcase
      end
      if (state == UPD) ptr <= ptr + 2'd1;
    end
  end

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Self-checking bench for a2d_rr_intf: behavioural ADC128S model on the SPI pins and a
// round-robin reference model of the four reading registers.
module tb_a2d_rr_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        cnv_cmplt, busy, SS_n, SCLK, MOSI;
  logic        miso = 1'b0;
  logic        miso_pin;

  assign miso_pin = rst_n ? miso : 1'b1;

  a2d_rr_intf dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .cnv_cmplt(cnv_cmplt), .busy(busy),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_pin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ADC model: channel values, and the address captured from the previous transaction.
  logic [11:0] adc_val [8];
  logic [2:0]  last_addr = 3'd0;
  logic [15:0] rx_word = 16'h0, resp = 16'h0;
  int          rx_bits = 0;
  logic        ss_prev = 1'b1, sclk_prev = 1'b1;
  logic [15:0] mosi_q [$];

  always @(SS_n, SCLK) begin
    if (ss_prev === 1'b1 && SS_n === 1'b0) begin
      rx_bits = 0;
      resp = {4'($urandom), adc_val[last_addr]};
      miso = resp[15];
    end else if (ss_prev === 1'b0 && SS_n === 1'b1) begin
      if (rx_bits == 16) begin
        mosi_q.push_back(rx_word);
        last_addr = rx_word[13:11];
      end
    end else if (SS_n === 1'b0 && sclk_prev === 1'b0 && SCLK === 1'b1) begin
      rx_word = {rx_word[14:0], MOSI};
      rx_bits++;
    end else if (SS_n === 1'b0 && sclk_prev === 1'b1 && SCLK === 1'b0 && rx_bits > 0 && rx_bits < 16) begin
      miso = resp[15 - rx_bits];
    end
    ss_prev = SS_n;
    sclk_prev = SCLK;
  end

  // Pin monitor: SS_n low/high run lengths, cnv_cmplt times, idle-SCLK and busy violations.
  int lo_run = 0, hi_run = 0, sclk_bad = 0, busy_bad = 0;
  int lo_q [$];
  int hi_q [$];
  int cnv_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      lo_run = 0;
      hi_run = 0;
    end else if (SS_n) begin
      if (lo_run > 0) lo_q.push_back(lo_run);
      lo_run = 0;
      hi_run++;
    end else begin
      if (hi_run > 0) hi_q.push_back(hi_run);
      hi_run = 0;
      lo_run++;
    end
    if (SS_n === 1'b1 && SCLK !== 1'b1) sclk_bad++;
    if (cnv_cmplt === 1'b1) begin
      cnv_q.push_back(cyc);
      if (busy !== 1'b0) busy_bad++;
    end
  end

  // Reference model: which register each conversion targets and what it must hold.
  int          chan_tbl [4] = '{0, 4, 5, 6};
  logic [11:0] exp_regs [4];
  int          exp_ptr = 0;
  int          lat_ref = 1044;

  function automatic logic [47:0] outs();
    return {lft_ld, rght_ld, steer_pot, batt};
  endfunction

  function automatic logic [47:0] exp_outs();
    return {exp_regs[0], exp_regs[1], exp_regs[2], exp_regs[3]};
  endfunction

  function automatic logic [15:0] exp_cmd();
    return 16'(chan_tbl[exp_ptr] * 2048);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_regs[i] = 12'h000;
    exp_ptr = 0;
  endtask

  task automatic model_convert();
    exp_regs[exp_ptr] = adc_val[chan_tbl[exp_ptr]];
    exp_ptr = (exp_ptr + 1) % 4;
  endtask

  task automatic pulse_nxt(output int t0);
    @(posedge clk); #1 nxt = 1'b1;
    @(negedge clk); t0 = cyc;
    @(posedge clk); #1 nxt = 1'b0;
  endtask

  task automatic wait_cnv(input int budget, output int tc, output bit ok);
    ok = 1'b0;
    tc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cnv_cmplt === 1'b1) begin
        ok = 1'b1;
        tc = cyc;
        return;
      end
    end
  endtask

  task automatic short_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    nxt = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (SS_n !== 1'b1 || SCLK !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_ss_sclk: %0d bad cycles, want 0", bad); end
    checks++;
    if (outs() !== 48'h0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs()); end
    checks++;
    if (cnv_cmplt !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: cnv_cmplt=%b busy=%b want 0 0", cnv_cmplt, busy);
    end
    checks++;
    if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    int t0, tc, lo0, hi0, m0;
    bit ok;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
    adc_val[0] = 12'h400;
    lo0 = lo_q.size(); hi0 = hi_q.size(); m0 = mosi_q.size();
    pulse_nxt(t0);
    wait_cnv(1200, tc, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout: no cnv_cmplt within 1200 clk");
    end else begin
      checks++;
      if (tc - t0 < 1043 || tc - t0 > 1045) begin
        errors++; $display("FAIL single_latency: got %0d want 1044", tc - t0);
      end
      lat_ref = tc - t0;
      model_convert();
      checks++;
      if (outs() !== exp_outs()) begin errors++; $display("FAIL single_outs: got %h want %h", outs(), exp_outs()); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0 with cnv_cmplt", busy); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (lo_q.size() < lo0 + 2 || hi_q.size() < hi0 + 2) begin
      errors++; $display("FAIL single_ss_count: lows %0d highs %0d want 2 2", lo_q.size() - lo0, hi_q.size() - hi0);
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (lo_q[lo0 + k] < 520 || lo_q[lo0 + k] > 521) begin
          errors++; $display("FAIL single_ss_low%0d: got %0d want 520", k, lo_q[lo0 + k]);
        end
      end
      checks++;
      if (hi_q[hi0 + 1] != 1) begin errors++; $display("FAIL single_gap: got %0d want 1", hi_q[hi0 + 1]); end
    end
    checks++;
    if (mosi_q.size() < m0 + 2) begin
      errors++; $display("FAIL single_mosi_count: got %0d want 2", mosi_q.size() - m0);
    end else if (mosi_q[m0] !== 16'h0000 || mosi_q[m0 + 1] !== 16'h0000) begin
      errors++; $display("FAIL single_mosi: got %h %h want 0000 0000", mosi_q[m0], mosi_q[m0 + 1]);
    end
  endtask

  task automatic test_round_robin();
    int t0, tc, m0;
    bit ok;
    short_reset();
    adc_val[0] = 12'h123; adc_val[4] = 12'h456; adc_val[5] = 12'h800; adc_val[6] = 12'hFFF;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) adc_val[0] = 12'h123 ^ 12'($urandom_range(1, 4095));
      m0 = mosi_q.size();
      pulse_nxt(t0);
      wait_cnv(1200, tc, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rr%0d_timeout: no cnv_cmplt within 1200 clk", i);
      end else begin
        checks++;
        if (tc - t0 != lat_ref) begin errors++; $display("FAIL rr%0d_latency: got %0d want %0d", i, tc - t0, lat_ref); end
        checks++;
        if (mosi_q.size() < m0 + 2 || mosi_q[m0] !== exp_cmd()) begin
          errors++; $display("FAIL rr%0d_mosi: got %h want %h", i, (mosi_q.size() > m0) ? mosi_q[m0] : 16'hxxxx, exp_cmd());
        end
        model_convert();
        checks++;
        if (outs() !== exp_outs()) begin errors++; $display("FAIL rr%0d_outs: got %h want %h", i, outs(), exp_outs()); end
      end
      while (cyc < t0 + 1200) @(posedge clk);
    end
  endtask

  task automatic test_ignored_nxt();
    int t0, c0, m0;
    c0 = cnv_q.size(); m0 = mosi_q.size();
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
    pulse_nxt(t0);
    foreach (adc_val[i]) ;
    while (cyc < t0 + 10) @(posedge clk);
    #1 nxt = 1'b1; @(posedge clk); #1 nxt = 1'b0;
    while (cyc < t0 + 600) @(posedge clk);
    #1 nxt = 1'b1; @(posedge clk); #1 nxt = 1'b0;
    while (cyc < t0 + 1150) @(posedge clk);
    checks++;
    if (cnv_q.size() - c0 != 1) begin errors++; $display("FAIL ignored_cnv_count: got %0d want 1", cnv_q.size() - c0); end
    checks++;
    if (mosi_q.size() - m0 != 2 || mosi_q[m0] !== exp_cmd()) begin
      errors++; $display("FAIL ignored_mosi: %0d words, first %h want 2 words, %h", mosi_q.size() - m0,
                         (mosi_q.size() > m0) ? mosi_q[m0] : 16'hxxxx, exp_cmd());
    end
    model_convert();
    @(negedge clk);
    checks++;
    if (outs() !== exp_outs()) begin errors++; $display("FAIL ignored_outs: got %h want %h", outs(), exp_outs()); end
  endtask

  task automatic test_back_to_back();
    int t0, c0, m0, sb0, bb0, in_win, waited;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
    c0 = cnv_q.size(); m0 = mosi_q.size(); sb0 = sclk_bad; bb0 = busy_bad;
    @(posedge clk); #1 nxt = 1'b1;
    @(negedge clk); t0 = cyc;
    repeat (5000) @(posedge clk);
    #1 nxt = 1'b0;
    waited = 0;
    while (cnv_q.size() < c0 + 5 && waited < 1500) begin @(negedge clk); waited++; end
    repeat (3) @(negedge clk);
    in_win = 0;
    for (int k = c0; k < cnv_q.size(); k++) if (cnv_q[k] <= t0 + 5000) in_win++;
    checks++;
    if (in_win != 4) begin errors++; $display("FAIL b2b_window_count: got %0d want 4", in_win); end
    checks++;
    if (cnv_q.size() - c0 != 5) begin
      errors++; $display("FAIL b2b_total: got %0d want 5", cnv_q.size() - c0);
    end else begin
      checks++;
      if (cnv_q[c0] - t0 != lat_ref) begin errors++; $display("FAIL b2b_first_lat: got %0d want %0d", cnv_q[c0] - t0, lat_ref); end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cnv_q[c0 + k + 1] - cnv_q[c0 + k] != lat_ref + 1) begin
          errors++; $display("FAIL b2b_interval%0d: got %0d want %0d", k, cnv_q[c0 + k + 1] - cnv_q[c0 + k], lat_ref + 1);
        end
      end
    end
    checks++;
    if (sclk_bad != sb0 || busy_bad != bb0) begin
      errors++; $display("FAIL b2b_idle_pins: sclk_bad %0d busy_bad %0d want 0 0", sclk_bad - sb0, busy_bad - bb0);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (mosi_q.size() < m0 + 2 * j + 2 || mosi_q[m0 + 2 * j] !== exp_cmd() || mosi_q[m0 + 2 * j + 1] !== exp_cmd()) begin
        errors++; $display("FAIL b2b_mosi%0d: want %h on both transactions", j, exp_cmd());
      end
      model_convert();
    end
    checks++;
    if (outs() !== exp_outs()) begin errors++; $display("FAIL b2b_outs: got %h want %h", outs(), exp_outs()); end
  endtask

  task automatic test_reset_mid_read();
    int t0, tc, c0, m0;
    bit ok;
    adc_val[0] = 12'($urandom_range(1, 4095));
    pulse_nxt(t0);
    while (cyc < t0 + 800) @(posedge clk);
    #1 rst_n = 1'b0;
    c0 = cnv_q.size();
    repeat (4) @(negedge clk);
    checks++;
    if (outs() !== 48'h0 || SS_n !== 1'b1 || SCLK !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_during: outs %h SS_n %b SCLK %b busy %b want 0 1 1 0", outs(), SS_n, SCLK, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    repeat (600) @(negedge clk);
    checks++;
    if (cnv_q.size() != c0 || outs() !== 48'h0) begin
      errors++; $display("FAIL midrst_after: %0d cnv, outs %h want 0 cnv, 0", cnv_q.size() - c0, outs());
    end
    m0 = mosi_q.size();
    pulse_nxt(t0);
    wait_cnv(1200, tc, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midrst_timeout: no cnv_cmplt within 1200 clk");
    end else begin
      checks++;
      if (mosi_q.size() < m0 + 2 || mosi_q[m0] !== 16'h0000) begin
        errors++; $display("FAIL midrst_mosi: got %h want 0000", (mosi_q.size() > m0) ? mosi_q[m0] : 16'hxxxx);
      end
      model_convert();
      checks++;
      if (outs() !== exp_outs()) begin errors++; $display("FAIL midrst_outs: got %h want %h", outs(), exp_outs()); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_ignored_nxt();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
